// File: rtl/jk_flip_flop.sv
// JK flip-flop built three ways (SR-, D- and T-based), each with its own state register.
// Optional feature macro: JK_MISMATCH_EN adds a combinational disagreement flag.

module sr_ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic s,
   input  logic r,
   output logic q
);

   // S=R=1 cannot occur from the JK excitation; hold in that case.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RST_VAL;
      end else if (s && !r) begin
         q <= 1'b1;
      end else if (r && !s) begin
         q <= 1'b0;
      end
   end

endmodule

module d_ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RST_VAL;
      end else begin
         q <= d;
      end
   end

endmodule

module t_ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RST_VAL;
      end else begin
         q <= q ^ t;
      end
   end

endmodule

module jk_flip_flop #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic J,
   input  logic K,
   output logic Q_sr,
   output logic Q_d,
`ifdef JK_MISMATCH_EN
   output logic Q_t,
   output logic mismatch
`else
   output logic Q_t
`endif
);

   logic s;
   logic r;
   logic d;
   logic t;

   // Each path derives its excitation only from its own register.
   assign s = J & ~Q_sr;
   assign r = K & Q_sr;
   assign d = (J & ~Q_d) | (~K & Q_d);
   assign t = (J & ~Q_t) | (K & Q_t);

   sr_ff #(.RST_VAL(RST_VAL)) u_sr (
      .clk (clk),
      .rst (rst),
      .s   (s),
      .r   (r),
      .q   (Q_sr)
   );

   d_ff #(.RST_VAL(RST_VAL)) u_d (
      .clk (clk),
      .rst (rst),
      .d   (d),
      .q   (Q_d)
   );

   t_ff #(.RST_VAL(RST_VAL)) u_t (
      .clk (clk),
      .rst (rst),
      .t   (t),
      .q   (Q_t)
   );

`ifdef JK_MISMATCH_EN
   assign mismatch = ~((Q_sr == Q_d) & (Q_d == Q_t));
`endif

endmodule

// File: tb/tb_jk_flip_flop.sv
// Self-checking bench for jk_flip_flop: directed scenarios plus random J/K against a
// characteristic-table reference model; covers the JK_MISMATCH_EN build when defined.

module tb_jk_flip_flop;

   logic clk;
   logic rst;
   logic J;
   logic K;
   logic Q_sr;
   logic Q_d;
   logic Q_t;
`ifdef JK_MISMATCH_EN
   logic mismatch;
`endif

   int   n_cmp;
   int   n_err;
   logic q_model;

   jk_flip_flop #(.RST_VAL(1'b0)) dut (
      .clk      (clk),
      .rst      (rst),
      .J        (J),
      .K        (K),
      .Q_sr     (Q_sr),
      .Q_d      (Q_d),
`ifdef JK_MISMATCH_EN
      .Q_t      (Q_t),
      .mismatch (mismatch)
`else
      .Q_t      (Q_t)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   // JK characteristic table applied to the model state.
   function automatic logic jk_next(input logic q, input logic j, input logic k);
      case ({j, k})
         2'b00:   return q;
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return ~q;
      endcase
   endfunction

   // Drive J/K on the falling edge, let one rising edge happen, settle 1 ns after it.
   task automatic drive_edge(input logic j, input logic k);
      @(negedge clk);
      J = j;
      K = k;
      @(posedge clk);
      if (!rst) q_model = jk_next(q_model, j, k);
      else      q_model = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      J = 1'b0;
      K = 1'b0;
      q_model = 1'b0;
      #1;
      n_cmp++;
      if ({Q_sr, Q_d, Q_t} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_t0: got %b required 000", {Q_sr, Q_d, Q_t});
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({Q_sr, Q_d, Q_t} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_edge: got %b required 000", {Q_sr, Q_d, Q_t});
      end
`ifdef JK_MISMATCH_EN
      n_cmp++;
      if (mismatch !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mismatch: got %b required 0", mismatch);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_set_hold;
      drive_edge(1'b1, 1'b0);
      n_cmp++;
      if ({Q_sr, Q_d, Q_t} !== 3'b111) begin
         n_err++;
         $display("FAIL set: got %b required 111", {Q_sr, Q_d, Q_t});
      end
      drive_edge(1'b0, 1'b0);
      n_cmp++;
      if ({Q_sr, Q_d, Q_t} !== 3'b111) begin
         n_err++;
         $display("FAIL hold: got %b required 111", {Q_sr, Q_d, Q_t});
      end
   endtask

   task automatic test_clear;
      drive_edge(1'b0, 1'b1);
      n_cmp++;
      if ({Q_sr, Q_d, Q_t} !== 3'b000) begin
         n_err++;
         $display("FAIL clear: got %b required 000", {Q_sr, Q_d, Q_t});
      end
   endtask

   task automatic test_toggle;
      logic [3:0] seq;
      seq = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         drive_edge(1'b1, 1'b1);
         n_cmp++;
         if ({Q_sr, Q_d, Q_t} !== {3{seq[i]}}) begin
            n_err++;
            $display("FAIL toggle[%0d]: got %b required %b", i, {Q_sr, Q_d, Q_t}, {3{seq[i]}});
         end
      end
   endtask

   // 00,01,10,11 repeated from Q=0 gives 0,0,1,0 every cycle.
   task automatic test_cycle;
      logic [3:0] seq;
      logic [1:0] jk;
      seq = 4'b0100;
      for (int i = 0; i < 9; i++) begin
         jk = 2'(i % 4);
         drive_edge(jk[1], jk[0]);
         n_cmp++;
         if ({Q_sr, Q_d, Q_t} !== {3{seq[i % 4]}}) begin
            n_err++;
            $display("FAIL cycle[%0d] jk=%b: got %b required %b", i, jk, {Q_sr, Q_d, Q_t},
                     {3{seq[i % 4]}});
         end
      end
      q_model = seq[0];
   endtask

   // Inputs changed away from the edge must not move the outputs.
   task automatic test_between_edges;
      drive_edge(1'b1, 1'b0);
      #1;
      J = 1'b0;
      K = 1'b1;
      #1;
      n_cmp++;
      if ({Q_sr, Q_d, Q_t} !== 3'b111) begin
         n_err++;
         $display("FAIL between_edges: got %b required 111", {Q_sr, Q_d, Q_t});
      end
   endtask

   task automatic test_async_reset;
      drive_edge(1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      q_model = 1'b0;
      n_cmp++;
      if ({Q_sr, Q_d, Q_t} !== 3'b000) begin
         n_err++;
         $display("FAIL async_reset: got %b required 000", {Q_sr, Q_d, Q_t});
      end
      drive_edge(1'b1, 1'b0);
      n_cmp++;
      if ({Q_sr, Q_d, Q_t} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_edge_j1: got %b required 000", {Q_sr, Q_d, Q_t});
      end
`ifdef JK_MISMATCH_EN
      n_cmp++;
      if (mismatch !== 1'b0) begin
         n_err++;
         $display("FAIL async_mismatch: got %b required 0", mismatch);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
      drive_edge(1'b1, 1'b0);
      n_cmp++;
      if ({Q_sr, Q_d, Q_t} !== 3'b111) begin
         n_err++;
         $display("FAIL post_reset_set: got %b required 111", {Q_sr, Q_d, Q_t});
      end
   endtask

   task automatic test_random;
      logic j;
      logic k;
      for (int i = 0; i < 300; i++) begin
         j = 1'($urandom_range(0, 1));
         k = 1'($urandom_range(0, 1));
         drive_edge(j, k);
         n_cmp++;
         if ({Q_sr, Q_d, Q_t} !== {3{q_model}}) begin
            n_err++;
            $display("FAIL random[%0d] jk=%b%b: got %b required %b", i, j, k,
                     {Q_sr, Q_d, Q_t}, {3{q_model}});
         end
`ifdef JK_MISMATCH_EN
         n_cmp++;
         if (mismatch !== 1'b0) begin
            n_err++;
            $display("FAIL random_mismatch[%0d]: got %b required 0", i, mismatch);
         end
`endif
         if ($urandom_range(0, 15) == 0) begin
            #1;
            rst = 1'b1;
            #1;
            q_model = 1'b0;
            n_cmp++;
            if ({Q_sr, Q_d, Q_t} !== 3'b000) begin
               n_err++;
               $display("FAIL random_reset[%0d]: got %b required 000", i, {Q_sr, Q_d, Q_t});
            end
            rst = 1'b0;
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset;
      test_set_hold;
      test_clear;
      test_toggle;
      test_cycle;
      test_between_edges;
      test_async_reset;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
